// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch sequencer for the multi-cycle MIPS datapath. On a request from the
// main control FSM it reads one word from instruction memory over a
// req/ready handshake. On success it captures the word and pulses IRWrite.
// Misaligned PCs, bus errors and timeouts are reported as faults instead.
//
// Parameters
//   TIMEOUT_CYCLES    max WAIT cycles without mem_ready (legal 2..255)
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   fetch_start       fetch request, sampled only in IDLE
//   pc[31:0]          fetch address, sampled with fetch_start
//   mem_req           read request to instruction memory
//   mem_addr[31:0]    latched fetch address
//   mem_ready         read data valid (only looked at in WAIT)
//   mem_rdata[31:0]   read data
//   mem_err           bus error (only looked at in WAIT, beats mem_ready)
//   IRWrite           one-cycle instruction register load strobe
//   instruction_next  captured instruction word (cleared to NOP on a fault)
//   fetch_done        one-cycle pulse, coincident with IRWrite
//   fetch_fault       one-cycle fault pulse
//   fault_cause[1:0]  01 misaligned, 10 bus error, 11 timeout; sticky
//   busy              high in every state except IDLE
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        IRWrite,
    output logic [31:0] instruction_next,
    output logic        fetch_done,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    localparam int unsigned CntW = 8;
    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CauseMisaligned = 2'b01;
    localparam logic [1:0] CauseBusErr     = 2'b10;
    localparam logic [1:0] CauseTimeout    = 2'b11;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWait  = 2'b01,
        StLoad  = 2'b10,
        StFault = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [1:0]      cause_q, cause_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            mem_addr_q <= 32'h0;
            instr_q    <= 32'h0;
            cause_q    <= 2'b00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_start) begin
                    if (pc[1:0] == 2'b00) begin
                        state_d    = StWait;
                        mem_addr_d = pc;
                        cnt_d      = '0;
                    end else begin
                        // No memory request for a misaligned address.
                        state_d = StFault;
                        cause_d = CauseMisaligned;
                        instr_d = 32'h0;
                    end
                end
            end

            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_err) begin
                    state_d = StFault;
                    cause_d = CauseBusErr;
                    instr_d = 32'h0;
                end else if (mem_ready) begin
                    // A response in the final cycle still beats the timeout.
                    state_d = StLoad;
                    instr_d = mem_rdata;
                end else if (cnt_q == CntLast) begin
                    state_d = StFault;
                    cause_d = CauseTimeout;
                    instr_d = 32'h0;
                end
            end

            StLoad: begin
                state_d = StIdle;
            end

            StFault: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state registers only, no input-to-output path
    // ------------------------------------------------------------------
    always_comb begin
        mem_req     = 1'b0;
        IRWrite     = 1'b0;
        fetch_done  = 1'b0;
        fetch_fault = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StWait: begin
                mem_req = 1'b1;
                busy    = 1'b1;
            end
            StLoad: begin
                IRWrite    = 1'b1;
                fetch_done = 1'b1;
                busy       = 1'b1;
            end
            StFault: begin
                fetch_fault = 1'b1;
                busy        = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr         = mem_addr_q;
    assign instruction_next = instr_q;
    assign fault_cause      = cause_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        IRWrite;
    logic [31:0] instruction_next;
    logic        fetch_done;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int n;

    instruction_fetch_unit #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_start     (fetch_start),
        .pc              (pc),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err),
        .IRWrite         (IRWrite),
        .instruction_next(instruction_next),
        .fetch_done      (fetch_done),
        .fetch_fault     (fetch_fault),
        .fault_cause     (fault_cause),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        fetch_start = 1'b0;
        pc          = 32'h0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        mem_err     = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", instruction_next, 32'h0);
        check("rst_cause", fault_cause, 0);
        reset = 1'b1;
        tick();

        // ---------------- zero-wait fetch ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0000;
        mem_rdata   = 32'h2008_0005;
        mem_ready   = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("zw_mem_req", mem_req, 1);
        check("zw_mem_addr", mem_addr, 32'h0040_0000);
        check("zw_busy", busy, 1);
        check("zw_irwrite_early", IRWrite, 0);
        tick();
        mem_ready = 1'b0;
        check("zw_irwrite", IRWrite, 1);
        check("zw_done", fetch_done, 1);
        check("zw_mem_req_off", mem_req, 0);
        check("zw_instr", instruction_next, 32'h2008_0005);
        tick();
        check("zw_irwrite_1cyc", IRWrite, 0);
        check("zw_idle", busy, 0);
        check("zw_instr_hold", instruction_next, 32'h2008_0005);

        // ---------------- misaligned pc ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0002;
        tick();
        fetch_start = 1'b0;
        check("mis_fault", fetch_fault, 1);
        check("mis_cause", fault_cause, 2'b01);
        check("mis_mem_req", mem_req, 0);
        check("mis_irwrite", IRWrite, 0);
        check("mis_instr", instruction_next, 32'h0);
        tick();
        check("mis_fault_1cyc", fetch_fault, 0);
        check("mis_cause_hold", fault_cause, 2'b01);
        check("mis_mem_req2", mem_req, 0);
        check("mis_idle", busy, 0);

        // ---------------- wait states, fetch_start ignored in WAIT ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0004;
        mem_rdata   = 32'h8C09_0010;
        tick();
        check("ws_req_1", mem_req, 1);
        for (int i = 1; i <= 4; i++) begin
            fetch_start = 1'b1;
            pc          = 32'h0040_0100;
            tick();
            check("ws_req_n", mem_req, 1);
            check("ws_addr_stable", mem_addr, 32'h0040_0004);
            check("ws_no_irwrite", IRWrite, 0);
        end
        fetch_start = 1'b0;
        mem_ready   = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("ws_irwrite", IRWrite, 1);
        check("ws_instr", instruction_next, 32'h8C09_0010);
        tick();
        check("ws_idle", busy, 0);
        tick();
        check("ws_no_second_req", mem_req, 0);

        // ---------------- mem_err beats mem_ready ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0008;
        tick();
        fetch_start = 1'b0;
        mem_err     = 1'b1;
        mem_ready   = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        tick();
        mem_err   = 1'b0;
        mem_ready = 1'b0;
        check("err_fault", fetch_fault, 1);
        check("err_cause", fault_cause, 2'b10);
        check("err_irwrite", IRWrite, 0);
        check("err_instr", instruction_next, 32'h0);
        tick();
        check("err_irwrite_after", IRWrite, 0);
        check("err_idle", busy, 0);

        // ---------------- timeout ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_000C;
        tick();
        fetch_start = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, 16);
        check("to_fault", fetch_fault, 1);
        check("to_cause", fault_cause, 2'b11);
        check("to_irwrite", IRWrite, 0);
        tick();
        check("to_idle", busy, 0);

        // ---------------- ready on the last WAIT cycle ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0010;
        mem_rdata   = 32'h0109_5020;
        tick();
        fetch_start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        check("last_req_16", mem_req, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("last_irwrite", IRWrite, 1);
        check("last_no_fault", fetch_fault, 0);
        check("last_instr", instruction_next, 32'h0109_5020);
        tick();

        // ---------------- reset mid-WAIT ----------------
        fetch_start = 1'b1;
        pc          = 32'h0040_0014;
        tick();
        fetch_start = 1'b0;
        tick();
        tick();
        check("mr_req_before", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_req_async", mem_req, 0);
        check("mr_busy_async", busy, 0);
        check("mr_addr_async", mem_addr, 32'h0);
        check("mr_instr_async", instruction_next, 32'h0);
        check("mr_cause_async", fault_cause, 0);
        tick();
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("mr_stray_irwrite", IRWrite, 0);
        check("mr_stray_busy", busy, 0);
        fetch_start = 1'b1;
        pc          = 32'h0040_0018;
        mem_rdata   = 32'h0000_0020;
        tick();
        fetch_start = 1'b0;
        check("mr_new_addr", mem_addr, 32'h0040_0018);
        tick();
        mem_ready = 1'b0;
        check("mr_new_irwrite", IRWrite, 1);
        check("mr_new_instr", instruction_next, 32'h0000_0020);
        tick();
        check("mr_new_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
